// File: rtl/m14k_ssram_sp_bw_ctl.sv
`default_nettype none
// m14k_ssram_sp_bw_ctl: single-port, byte-writable line SRAM with an init/flush sweep,
// write-first read-during-write and an optional output register.      Rev 1.0
module m14k_ssram_sp_bw_ctl #(
  parameter int BYTES          = 64,
  parameter int BITS_PER_BYTE  = 8,
  parameter int BYTES_PER_WORD = 4,
  parameter int WORDS_PER_LINE = 4,
  parameter int LIDX_SIZE      = 2,
  parameter int OUT_REG        = 0,
  parameter logic [BITS_PER_BYTE-1:0] INIT_VALUE = '0
) (
  input  logic                                                   clk,
  input  logic                                                   rst_n,
  input  logic                                                   flush,
  input  logic [LIDX_SIZE-1:0]                                   line_idx,
  input  logic [BYTES_PER_WORD*WORDS_PER_LINE-1:0]               wr_mask,
  input  logic                                                   rd_str,
  input  logic                                                   wr_str,
  input  logic [BITS_PER_BYTE*BYTES_PER_WORD-1:0]                wr_data,
  output logic [BITS_PER_BYTE*BYTES_PER_WORD*WORDS_PER_LINE-1:0] rd_data,
  output logic                                                   rd_valid,
  output logic                                                   ready
);

  localparam int LINE_BYTES = BYTES_PER_WORD * WORDS_PER_LINE;
  localparam int LINE_WIDTH = BITS_PER_BYTE * LINE_BYTES;
  localparam int DEPTH      = BYTES / LINE_BYTES;
  localparam logic [LIDX_SIZE-1:0] LAST_LINE = LIDX_SIZE'(DEPTH - 1);

  typedef enum logic [0:0] {
    ST_INIT = 1'b0,
    ST_IDLE = 1'b1
  } state_t;

  state_t                state, state_nxt;
  logic [LIDX_SIZE-1:0]  sweep_cnt, sweep_cnt_nxt;
  logic [LINE_WIDTH-1:0] mem [DEPTH];
  logic [LINE_WIDTH-1:0] cur_line;
  logic [LINE_WIDTH-1:0] merged_line;
  logic [LINE_BYTES-1:0] byte_we;
  logic                  rd_acc;
  logic                  wr_acc;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_INIT;
      sweep_cnt <= '0;
    end else begin
      state     <= state_nxt;
      sweep_cnt <= sweep_cnt_nxt;
    end
  end

  always_comb begin
    state_nxt     = state;
    sweep_cnt_nxt = sweep_cnt;
    case (state)
      ST_INIT: begin
        if (flush) begin
          sweep_cnt_nxt = '0;
        end else if (sweep_cnt == LAST_LINE) begin
          state_nxt     = ST_IDLE;
          sweep_cnt_nxt = '0;
        end else begin
          sweep_cnt_nxt = sweep_cnt + LIDX_SIZE'(1);
        end
      end
      default: begin
        if (flush) begin
          state_nxt     = ST_INIT;
          sweep_cnt_nxt = '0;
        end
      end
    endcase
  end

  assign ready  = (state == ST_IDLE);
  // Flush wins over strobes sampled on the same edge.
  assign rd_acc = ready & ~flush & rd_str;
  assign wr_acc = ready & ~flush & wr_str;

  assign byte_we  = {LINE_BYTES{wr_acc}} & wr_mask;
  assign cur_line = mem[line_idx];

  // The write word is replicated across the line; the merged line feeds both the
  // array write and the same-cycle read, which gives write-first behaviour.
  for (genvar b = 0; b < LINE_BYTES; b++) begin : g_byte
    localparam int WB = b % BYTES_PER_WORD;
    assign merged_line[b*BITS_PER_BYTE +: BITS_PER_BYTE] =
      byte_we[b] ? wr_data[WB*BITS_PER_BYTE +: BITS_PER_BYTE]
                 : cur_line[b*BITS_PER_BYTE +: BITS_PER_BYTE];
  end

  always_ff @(posedge clk) begin
    if (state == ST_INIT) begin
      mem[sweep_cnt] <= {LINE_BYTES{INIT_VALUE}};
    end else if (wr_acc) begin
      mem[line_idx] <= merged_line;
    end
  end

  if (OUT_REG != 0) begin : g_out_reg
    logic                  s1_valid;
    logic [LINE_WIDTH-1:0] s1_data;

    // Second stage drains regardless of state so an accepted read always completes.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        s1_valid <= 1'b0;
        s1_data  <= '0;
        rd_valid <= 1'b0;
        rd_data  <= '0;
      end else begin
        s1_valid <= rd_acc;
        if (rd_acc) s1_data <= merged_line;
        rd_valid <= s1_valid;
        if (s1_valid) rd_data <= s1_data;
      end
    end
  end else begin : g_no_out_reg
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        rd_valid <= 1'b0;
        rd_data  <= '0;
      end else begin
        rd_valid <= rd_acc;
        if (rd_acc) rd_data <= merged_line;
      end
    end
  end

endmodule
`default_nettype wire

// File: doc/m14k_ssram_sp_bw_ctl.md
# m14k_ssram_sp_bw_ctl

Parametrised, synthesizable, single-ported, byte-writable line SRAM for M14K cache data and tag arrays. Writes are one word at a time through a byte mask; reads return a full line. It adds three things: a hardware initialisation/flush sweep, deterministic write-first read-during-write, and an optional output register stage. It sits between the cache controller and the storage, replacing simulation-only array models.

## Interface
- BYTES, 64: total capacity in bytes.
- BITS_PER_BYTE, 8: width of one write-selectable byte.
- BYTES_PER_WORD, 4: width of the write unit, in bytes.
- WORDS_PER_LINE, 4: width of the read unit, in words.
- LIDX_SIZE, 2: line index width; must satisfy 2^LIDX_SIZE == BYTES/(BYTES_PER_WORD*WORDS_PER_LINE) (Depth).
- OUT_REG, 0: 0 gives 1-cycle read latency; 1 adds an output register (2-cycle latency).
- INIT_VALUE, 0: per-byte value written by the init/flush sweep.
- clk  input  1  clock; all state changes on rising edge.
- rst_n  input  1  reset, asynchronous, active-low.
- flush  input  1  one-cycle request to re-run the init sweep.
- line_idx  input  LIDX_SIZE  line index for the read/write.
- wr_mask  input  BYTES_PER_WORD*WORDS_PER_LINE  byte-enable mask across the line.
- rd_str  input  1  read strobe.
- wr_str  input  1  write strobe.
- wr_data  input  BITS_PER_BYTE*BYTES_PER_WORD  write word; replicated across all words of the line.
- rd_data  output  LINE_WIDTH  read line, held until the next read completes.
- rd_valid  output  1  one-cycle pulse when rd_data is updated.
- ready  output  1  array initialised; strobes accepted only while high.

## Operation
- States: INIT, IDLE. Reset forces INIT with sweep counter 0.
- INIT: every rising edge writes INIT_VALUE to every byte of line[counter], then counter+1.
  - After writing line Depth-1, go to IDLE and set ready=1.
  - rd_str, wr_str and wr_mask are ignored: no array change, no rd_valid.
- IDLE, flush=1: go to INIT, counter=0, ready=0. Flush takes priority over same-cycle strobes; those strobes are dropped.
- INIT, flush=1: counter restarts at 0.
- Write (IDLE, wr_str=1): for each set bit i of wr_mask, byte i of line[line_idx] = byte (i mod BYTES_PER_WORD) of wr_data. Other bytes are unchanged. wr_mask=0 writes nothing.
- Read (IDLE, rd_str=1): returns line[line_idx].
- rd_str=1 and wr_str=1 in the same cycle: the write is performed and the read returns the post-write (merged) line (write-first).
- No strobe: rd_data holds, rd_valid=0.
- The array is not cleared by rst_n itself; the sweep clears it.
- Read pipeline under OUT_REG=1: the second stage completes even if flush or rst_n-free INIT begins. Only rst_n clears the pipeline.

## Timing
- Reset values: rd_data=0, rd_valid=0, ready=0, state=INIT, counter=0, output pipeline cleared.
- Init: the first rising edge after rst_n deasserts writes line 0. Edge number Depth writes line Depth-1 and sets ready=1. Strobes are first accepted on edge Depth+1.
- Flush: flush is sampled at edge N, so ready=0 after edge N. Line 0 is written at edge N+1, and ready=1 after edge N+Depth.
- OUT_REG=0: rd_data and rd_valid update at the same edge that samples rd_str.
- OUT_REG=1: they update one edge later. Back-to-back reads are accepted every cycle, giving one rd_valid per accepted read, in order.
- A write is visible to a read in the next cycle, or in the same cycle under the write-first rule.
- rst_n assertion mid-sweep or mid-read: outputs go to reset values immediately, without a clock.

## Test plan
- Reset release with defaults (Depth=4) -> ready=0 for edges 1-3, ready=1 after edge 4. Reading lines 0-3 returns 128'h0 with a single rd_valid pulse each.
- Write line 2, wr_mask=16'h00F0, wr_data=32'hDEADBEEF, then read line 2 -> rd_data=128'h00000000_00000000_DEADBEEF_00000000. Lines 0, 1, 3 stay 0.
- Write line 1, wr_mask=16'h0003, wr_data=32'h11223344, together with rd_str on line 1 -> same-cycle rd_data=128'h...00003344 (write-first); a later read gives the same value.
- Write all lines nonzero, then pulse flush together with wr_str -> ready low for 4 edges, the strobe is dropped, and all lines read 0 afterwards. A second flush mid-sweep extends the busy time by restarting at line 0.
- OUT_REG=1: reads on lines 0, 1, 2 on consecutive cycles -> rd_valid high for 3 cycles starting one edge late, with data in order.
- Assert rst_n during INIT with OUT_REG=1 and a read in flight -> rd_valid and rd_data clear asynchronously, and the sweep restarts from line 0 on release.
